// File: rtl/fb_apply_sequencer.sv
// rtl/fb_apply_sequencer.sv - drains the pipeline, pulses color/depth apply and waits for the applied handshake.
// Optional FB_SEQ_TIMEOUT_EN adds a WAIT_START timeout that sets a sticky error.
module fb_apply_sequencer #(
  parameter int CLEAR_WIDTH    = 16,
  parameter int TIMEOUT_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_commit,
  input  logic                   cmd_memset_color,
  input  logic                   cmd_memset_depth,
  input  logic [CLEAR_WIDTH-1:0] cmd_clear_color,
  input  logic [CLEAR_WIDTH-1:0] cmd_clear_depth,
  input  logic                   pipeline_idle,
  output logic                   pipeline_hold,
  output logic                   color_apply,
  output logic                   color_cmdCommit,
  output logic                   color_cmdMemset,
  input  logic                   color_applied,
  output logic                   depth_apply,
  output logic                   depth_cmdMemset,
  input  logic                   depth_applied,
  output logic [CLEAR_WIDTH-1:0] color_clear,
  output logic [CLEAR_WIDTH-1:0] depth_clear,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  typedef enum logic [2:0] {IDLE, DRAIN, ISSUE, WAIT_START, WAIT_DONE} state_t;

  state_t                 state_q;
  logic                   commit_q, mset_color_q, mset_depth_q;
  logic [CLEAR_WIDTH-1:0] color_clear_q, depth_clear_q;
  logic                   color_apply_q, depth_apply_q, done_q;
  logic                   color_started_q, depth_started_q;
  logic                   color_done_q, depth_done_q;
  logic                   need_color, need_depth, start_ok, done_ok;
`ifdef FB_SEQ_TIMEOUT_EN
  logic [15:0]            to_cnt_q;
  logic                   error_q;
`endif

  assign need_color = commit_q | mset_color_q;
  assign need_depth = mset_depth_q;

  // Per-buffer latches let each buffer complete its phase in a different cycle.
  assign start_ok = (!need_color || color_started_q || !color_applied) &&
                    (!need_depth || depth_started_q || !depth_applied);
  assign done_ok  = (!need_color || color_done_q || color_applied) &&
                    (!need_depth || depth_done_q || depth_applied);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      commit_q        <= 1'b0;
      mset_color_q    <= 1'b0;
      mset_depth_q    <= 1'b0;
      color_clear_q   <= '0;
      depth_clear_q   <= '0;
      color_apply_q   <= 1'b0;
      depth_apply_q   <= 1'b0;
      done_q          <= 1'b0;
      color_started_q <= 1'b0;
      depth_started_q <= 1'b0;
      color_done_q    <= 1'b0;
      depth_done_q    <= 1'b0;
`ifdef FB_SEQ_TIMEOUT_EN
      to_cnt_q        <= '0;
      error_q         <= 1'b0;
`endif
    end else begin
      color_apply_q <= 1'b0;
      depth_apply_q <= 1'b0;
      done_q        <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            commit_q      <= cmd_commit;
            mset_color_q  <= cmd_memset_color;
            mset_depth_q  <= cmd_memset_depth;
            color_clear_q <= cmd_clear_color;
            depth_clear_q <= cmd_clear_depth;
            // A command with no work completes straight from IDLE.
            if (cmd_commit || cmd_memset_color || cmd_memset_depth) state_q <= DRAIN;
            else done_q <= 1'b1;
          end
        end
        DRAIN: begin
          if (pipeline_idle) begin
            state_q         <= ISSUE;
            color_apply_q   <= need_color;
            depth_apply_q   <= need_depth;
            color_started_q <= 1'b0;
            depth_started_q <= 1'b0;
            color_done_q    <= 1'b0;
            depth_done_q    <= 1'b0;
`ifdef FB_SEQ_TIMEOUT_EN
            to_cnt_q        <= '0;
`endif
          end
        end
        ISSUE: state_q <= WAIT_START;
        WAIT_START: begin
          if (need_color && !color_applied) color_started_q <= 1'b1;
          if (need_depth && !depth_applied) depth_started_q <= 1'b1;
          if (start_ok) begin
            state_q <= WAIT_DONE;
`ifdef FB_SEQ_TIMEOUT_EN
          end else if (to_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
            error_q      <= 1'b1;
            done_q       <= 1'b1;
            state_q      <= IDLE;
            commit_q     <= 1'b0;
            mset_color_q <= 1'b0;
            mset_depth_q <= 1'b0;
          end else begin
            to_cnt_q <= to_cnt_q + 16'd1;
`endif
          end
        end
        WAIT_DONE: begin
          if (need_color && color_applied) color_done_q <= 1'b1;
          if (need_depth && depth_applied) depth_done_q <= 1'b1;
          if (done_ok) begin
            done_q       <= 1'b1;
            state_q      <= IDLE;
            commit_q     <= 1'b0;
            mset_color_q <= 1'b0;
            mset_depth_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready       = (state_q == IDLE);
  assign busy            = (state_q != IDLE);
  assign pipeline_hold   = busy;
  assign color_apply     = color_apply_q;
  assign depth_apply     = depth_apply_q;
  assign color_cmdCommit = commit_q;
  assign color_cmdMemset = mset_color_q;
  assign depth_cmdMemset = mset_depth_q;
  assign color_clear     = color_clear_q;
  assign depth_clear     = depth_clear_q;
  assign done            = done_q;
`ifdef FB_SEQ_TIMEOUT_EN
  assign error           = error_q;
`else
  assign error           = 1'b0;
`endif

endmodule

// File: tb/tb_fb_apply_sequencer.sv
// tb/tb_fb_apply_sequencer.sv - directed self-checking bench for fb_apply_sequencer.
module tb_fb_apply_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic        cmd_commit, cmd_memset_color, cmd_memset_depth;
  logic [15:0] cmd_clear_color, cmd_clear_depth;
  logic        pipeline_idle, pipeline_hold;
  logic        color_apply, color_cmdCommit, color_cmdMemset, color_applied;
  logic        depth_apply, depth_cmdMemset, depth_applied;
  logic [15:0] color_clear, depth_clear;
  logic        busy, done, error;

  int checks   = 0;
  int failures = 0;
  int c_pulses = 0;
  int d_pulses = 0;
  int c_snap, d_snap;

  fb_apply_sequencer #(.CLEAR_WIDTH(16), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_commit(cmd_commit), .cmd_memset_color(cmd_memset_color), .cmd_memset_depth(cmd_memset_depth),
    .cmd_clear_color(cmd_clear_color), .cmd_clear_depth(cmd_clear_depth),
    .pipeline_idle(pipeline_idle), .pipeline_hold(pipeline_hold),
    .color_apply(color_apply), .color_cmdCommit(color_cmdCommit), .color_cmdMemset(color_cmdMemset),
    .color_applied(color_applied),
    .depth_apply(depth_apply), .depth_cmdMemset(depth_cmdMemset), .depth_applied(depth_applied),
    .color_clear(color_clear), .depth_clear(depth_clear),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (color_apply === 1'b1) c_pulses <= c_pulses + 1;
    if (depth_apply === 1'b1) d_pulses <= d_pulses + 1;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic c, input logic mc, input logic md, input logic [15:0] cc, input logic [15:0] dc);
    cmd_valid        = 1'b1;
    cmd_commit       = c;
    cmd_memset_color = mc;
    cmd_memset_depth = md;
    cmd_clear_color  = cc;
    cmd_clear_depth  = dc;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_commit = 1'b0; cmd_memset_color = 1'b0; cmd_memset_depth = 1'b0;
    cmd_clear_color = 16'h0; cmd_clear_depth = 16'h0;
    pipeline_idle = 1'b1; color_applied = 1'b1; depth_applied = 1'b1;
    tick(); tick();
    chk("rst_ready", cmd_ready, 1); chk("rst_busy", busy, 0); chk("rst_hold", pipeline_hold, 0);
    chk("rst_capply", color_apply, 0); chk("rst_dapply", depth_apply, 0);
    chk("rst_flags", {color_cmdCommit, color_cmdMemset, depth_cmdMemset}, 0);
    chk("rst_done", done, 0); chk("rst_error", error, 0);
    chk("rst_cclr", color_clear, 0); chk("rst_dclr", depth_clear, 0);
    reset = 1'b0;
    tick();

    // Commit + memset color, 20-cycle apply
    c_snap = c_pulses; d_snap = d_pulses;
    send(1, 1, 0, 16'h1234, 16'h5678);
    tick(); cmd_valid = 1'b0;
    chk("a_busy", busy, 1); chk("a_ready", cmd_ready, 0); chk("a_hold", pipeline_hold, 1);
    chk("a_commit", color_cmdCommit, 1); chk("a_cmset", color_cmdMemset, 1); chk("a_cclr", color_clear, 16'h1234);
    tick(); chk("a_apply_hi", color_apply, 1); chk("a_dapply", depth_apply, 0);
    tick(); chk("a_apply_lo", color_apply, 0);
    color_applied = 1'b0;
    tick();
    for (int i = 0; i < 19; i++) begin
      chk("a_wait_done", done, 0);
      chk("a_flags_steady", {color_cmdCommit, color_cmdMemset, pipeline_hold}, 3'b111);
      chk("a_cclr_steady", color_clear, 16'h1234);
      tick();
    end
    color_applied = 1'b1;
    tick(); chk("a_done", done, 1); chk("a_idle", cmd_ready, 1);
    tick(); chk("a_done_pulse", done, 0);
    chk("a_cpulses", c_pulses - c_snap, 1); chk("a_dpulses", d_pulses - d_snap, 0);

    // memset depth only, color_applied ignored
    c_snap = c_pulses; d_snap = d_pulses;
    send(0, 0, 1, 16'h0000, 16'hFFFF);
    tick(); cmd_valid = 1'b0;
    tick(); chk("b_dapply", depth_apply, 1); chk("b_capply", color_apply, 0); chk("b_dclr", depth_clear, 16'hFFFF);
    chk("b_dmset", depth_cmdMemset, 1);
    tick(); depth_applied = 1'b0;
    tick(); tick(); tick();
    chk("b_not_done", done, 0);
    depth_applied = 1'b1;
    tick(); chk("b_done", done, 1);
    tick(); chk("b_cpulses", c_pulses - c_snap, 0); chk("b_dpulses", d_pulses - d_snap, 1);

    // Both buffers, depth finishes 5 cycles early and then drops again
    c_snap = c_pulses; d_snap = d_pulses;
    send(0, 1, 1, 16'hAAAA, 16'h5555);
    tick(); cmd_valid = 1'b0;
    tick(); chk("c_capply", color_apply, 1); chk("c_dapply", depth_apply, 1);
    tick(); color_applied = 1'b0; depth_applied = 1'b0;
    tick(); depth_applied = 1'b1;
    tick(); depth_applied = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("c_wait_color", done, 0);
      tick();
    end
    color_applied = 1'b1;
    tick(); chk("c_done", done, 1);
    depth_applied = 1'b1;
    tick(); chk("c_cpulses", c_pulses - c_snap, 1); chk("c_dpulses", d_pulses - d_snap, 1);

    // Drain stall with a second command stalled behind the first
    c_snap = c_pulses;
    pipeline_idle = 1'b0;
    send(1, 0, 0, 16'h0D0D, 16'h0);
    tick(); cmd_clear_color = 16'hBEEF;
    for (int i = 0; i < 10; i++) begin
      chk("d_hold", pipeline_hold, 1); chk("d_no_apply", color_apply, 0);
      chk("d_stalled", cmd_ready, 0); chk("d_cclr", color_clear, 16'h0D0D);
      tick();
    end
    pipeline_idle = 1'b1;
    chk("d_apply_late", color_apply, 0);
    tick(); chk("d_apply", color_apply, 1);
    tick(); color_applied = 1'b0;
    tick(); color_applied = 1'b1;
    tick(); chk("d_done", done, 1); chk("d_cclr_keep", color_clear, 16'h0D0D);
    tick(); cmd_valid = 1'b0;
    chk("d_second_acc", busy, 1); chk("d_second_cclr", color_clear, 16'hBEEF);
    tick(); tick(); color_applied = 1'b0;
    tick(); color_applied = 1'b1;
    tick(); chk("d_second_done", done, 1);
    tick(); chk("d_cpulses", c_pulses - c_snap, 2);

    // No-op command
    c_snap = c_pulses; d_snap = d_pulses;
    send(0, 0, 0, 16'h1111, 16'h2222);
    tick(); cmd_valid = 1'b0;
    chk("e_done", done, 1); chk("e_hold", pipeline_hold, 0);
    tick(); chk("e_done_pulse", done, 0);
    tick(); chk("e_no_apply", (c_pulses - c_snap) + (d_pulses - d_snap), 0);

    // applied never drops while waiting to start
    send(1, 0, 0, 16'h3333, 16'h0);
    tick(); cmd_valid = 1'b0;
    tick(); tick();
`ifdef FB_SEQ_TIMEOUT_EN
    tick(); tick(); tick();
    chk("t_no_err_yet", error, 0); chk("t_busy", busy, 1);
    tick();
    chk("t_error", error, 1); chk("t_done", done, 1); chk("t_ready", cmd_ready, 1);
    tick(); chk("t_sticky", error, 1);
`else
    for (int i = 0; i < 10; i++) tick();
    chk("t_still_busy", busy, 1); chk("t_no_error", error, 0);
    color_applied = 1'b0;
    tick(); color_applied = 1'b1;
    tick(); chk("t_done", done, 1);
    tick();
`endif

    // Reset in WAIT_DONE
    send(1, 1, 0, 16'h7777, 16'h8888);
    tick(); cmd_valid = 1'b0;
    tick(); tick(); color_applied = 1'b0;
    tick();
    chk("g_in_wait", busy, 1);
    c_snap = c_pulses; d_snap = d_pulses;
    reset = 1'b1;
    tick();
    chk("g_ready", cmd_ready, 1); chk("g_busy", busy, 0); chk("g_hold", pipeline_hold, 0);
    chk("g_apply", {color_apply, depth_apply}, 0);
    chk("g_flags", {color_cmdCommit, color_cmdMemset, depth_cmdMemset}, 0);
    chk("g_done", done, 0); chk("g_error", error, 0);
    chk("g_clr", {color_clear, depth_clear}, 0);
    reset = 1'b0; color_applied = 1'b1;
    tick(); tick(); tick();
    chk("g_no_pulse", (c_pulses - c_snap) + (d_pulses - d_snap), 0);
    chk("g_stays_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fb_apply_sequencer.md
FB_APPLY_SEQUENCER -- requirements
Module: fb_apply_sequencer

Interface
REQ-001 SHALL have parameter CLEAR_WIDTH, default 16, width of clear values.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4, maximum cycles allowed between apply and applied falling.
REQ-003 clk  in  1  clock; all logic rising-edge.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 cmd_valid  in  1  command present; cmd_ready  out  1  sequencer accepts command.
REQ-006 cmd_commit, cmd_memset_color, cmd_memset_depth  in  1 each  requested operations.
REQ-007 cmd_clear_color, cmd_clear_depth  in  CLEAR_WIDTH each  clear values.
REQ-008 pipeline_idle  in  1  rasterizer has no fragment writes in flight.
REQ-009 pipeline_hold  out  1  stalls fragment issue while a command runs.
REQ-010 color_apply, color_cmdCommit, color_cmdMemset  out  1 each; color_applied  in  1.
REQ-011 depth_apply, depth_cmdMemset  out  1 each; depth_applied  in  1.
REQ-012 color_clear, depth_clear  out  CLEAR_WIDTH  registered clear values.
REQ-013 busy  out  1; done  out  1  one-cycle completion pulse; error  out  1  sticky timeout flag.

Function
REQ-014 States: IDLE, DRAIN, ISSUE, WAIT_START, WAIT_DONE.
REQ-015 cmd_ready SHALL be 1 only in IDLE; handshake is cmd_valid && cmd_ready.
REQ-016 On handshake: latch all cmd_* fields and clear values; assert pipeline_hold; go to DRAIN.
REQ-017 A command with commit=0 and both memsets=0 SHALL be accepted, produce done one cycle later, and never pulse apply.
REQ-018 DRAIN: remain until pipeline_idle=1, then go to ISSUE.
REQ-019 ISSUE (one cycle): pulse color_apply if commit or memset_color; pulse depth_apply if memset_depth; drive cmdCommit/cmdMemset flags steady from latch through WAIT_DONE.
REQ-020 Apply outputs SHALL be high for exactly one cycle per command.
REQ-021 WAIT_START: wait until every pulsed buffer shows applied=0, then go to WAIT_DONE.
REQ-022 WAIT_DONE: wait until every pulsed buffer shows applied=1; then done=1 for one cycle, pipeline_hold=0, and return to IDLE.
REQ-023 Non-pulsed buffers' applied inputs SHALL be ignored.
REQ-024 Buffers finishing in different cycles: completion requires both; the early one is held via a per-buffer done latch.
REQ-025 busy = (state != IDLE); pipeline_hold = busy.
REQ-026 New cmd_valid during busy SHALL be stalled (cmd_ready=0), never dropped.
REQ-027 Clear outputs SHALL stay stable from ISSUE through WAIT_DONE.

Reset
REQ-028 Reset SHALL force IDLE, with cmd_ready=1, every apply=0, cmd flags=0, pipeline_hold=0, busy=0, done=0, error=0, and clear outputs=0.
REQ-029 Reset mid-operation SHALL abandon the command immediately, issuing no further apply pulse.

Configuration
REQ-030 Macro FB_SEQ_TIMEOUT_EN.
REQ-031 Defined: a counter starts in WAIT_START; if TIMEOUT_CYCLES elapse without the required applied=0, set error=1 (sticky until reset), pulse done, and return to IDLE.
REQ-032 Undefined: no counter; WAIT_START waits indefinitely and error is tied to 0.

Verification
REQ-033 Commit+memset_color: color_applied drops 1 cycle after apply and rises 20 cycles later -> color_cmdCommit=1 and color_cmdMemset=1 throughout; exactly one apply pulse; done 1 cycle after the rise.
REQ-034 memset_depth only, clear 16'hFFFF -> depth_apply pulses once, depth_clear=16'hFFFF, color_apply stays 0.
REQ-035 Both buffers, depth finishes 5 cycles before color -> done only after color_applied=1.
REQ-036 pipeline_idle=0 for 10 cycles after accept -> no apply until the cycle after pipeline_idle=1; pipeline_hold=1 throughout.
REQ-037 FB_SEQ_TIMEOUT_EN defined, applied held at 1 -> error=1 after 4 cycles, then IDLE with cmd_ready=1.
REQ-038 Reset asserted in WAIT_DONE -> next cycle IDLE, all outputs at reset values, no apply pulse.
